// File: rtl/pingpong_line_buf.sv
// Two-bank ping-pong pixel line buffer: the writer fills one bank while the reader drains the other.
// A bank is offered to the reader only once it is closed (full or cut short by wr_last_in).
module pingpong_line_buf #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 10,
  parameter int BANK_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_in,
  input  logic              wr_valid_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              wr_last_in,
  output logic              wr_ready_out,
  output logic              pingpong_ready_out,
  input  logic              read_pingpong_in,
  output logic [DATA_W-1:0] pingpong_data_out,
  output logic              pingpong_data_valid_out,
  output logic              underrun_out,
  output logic [1:0]        bank_full_out
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(BANK_LEN-1);

  logic [DATA_W-1:0] r_mem [2][BANK_LEN];
  logic [DATA_W-1:0] r_rd_data;
  logic [1:0]        r_full;
  logic [ADDR_W:0]   r_cnt [2];
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_valid;
  logic              r_underrun;

  logic w_run;
  logic w_wr_ready;
  logic w_wr_acc;
  logic w_wr_close;
  logic w_rd_acc;
  logic w_rd_last;

  // Flush and reset block both ports in their cycle, including the RAM write.
  assign w_run      = rst_n & ~flush_in;
  assign w_wr_ready = ~r_full[r_wr_bank];
  assign w_wr_acc   = w_run & wr_valid_in & w_wr_ready;
  assign w_wr_close = w_wr_acc & ((r_wr_addr == ADDR_END) | wr_last_in);
  assign w_rd_acc   = w_run & read_pingpong_in & r_full[r_rd_bank];
  assign w_rd_last  = w_rd_acc & ({1'b0, r_rd_addr} == (r_cnt[r_rd_bank] - CNT_ONE));

  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_bank][r_wr_addr] <= wr_data_in;
    if (w_rd_acc)
      r_rd_data <= r_mem[r_rd_bank][r_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_in) begin
      r_full     <= '0;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (read_pingpong_in && !r_full[r_rd_bank])
        r_underrun <= 1'b1;

      // Close and release always target different banks, so both full bits may update together.
      if (w_wr_close) begin
        r_full[r_wr_bank] <= 1'b1;
        r_cnt[r_wr_bank]  <= {1'b0, r_wr_addr} + CNT_ONE;
        r_wr_addr         <= '0;
        r_wr_bank         <= ~r_wr_bank;
      end else if (w_wr_acc) begin
        r_wr_addr <= r_wr_addr + ADDR_ONE;
      end

      if (w_rd_last) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_addr         <= '0;
        r_rd_bank         <= ~r_rd_bank;
      end else if (w_rd_acc) begin
        r_rd_addr <= r_rd_addr + ADDR_ONE;
      end
    end
  end

  assign wr_ready_out            = w_wr_ready;
  assign pingpong_ready_out      = r_full[r_rd_bank];
  assign pingpong_data_valid_out = r_valid;
  assign pingpong_data_out       = r_valid ? r_rd_data : '0;
  assign underrun_out            = r_underrun;
  assign bank_full_out           = r_full;

endmodule

// File: tb/tb_pingpong_line_buf.sv
// Bench for pingpong_line_buf: table-driven control checks plus a read-data scoreboard.
module tb_pingpong_line_buf;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_in;
  logic          wr_valid_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_last_in;
  logic          wr_ready_out;
  logic          pingpong_ready_out;
  logic          read_pingpong_in;
  logic [DW-1:0] pingpong_data_out;
  logic          pingpong_data_valid_out;
  logic          underrun_out;
  logic [1:0]    bank_full_out;

  pingpong_line_buf #(.DATA_W(DW), .ADDR_W(3), .BANK_LEN(8)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush_in                (flush_in),
    .wr_valid_in             (wr_valid_in),
    .wr_data_in              (wr_data_in),
    .wr_last_in              (wr_last_in),
    .wr_ready_out            (wr_ready_out),
    .pingpong_ready_out      (pingpong_ready_out),
    .read_pingpong_in        (read_pingpong_in),
    .pingpong_data_out       (pingpong_data_out),
    .pingpong_data_valid_out (pingpong_data_valid_out),
    .underrun_out            (underrun_out),
    .bank_full_out           (bank_full_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ping-pong preserves write order, so every valid word must match the oldest unread write.
  always @(negedge clk) begin
    if (pingpong_data_valid_out === 1'b1) begin
      if (exp_q.size() == 0) chk("valid_without_pending_word", 32'd1, 32'd0);
      else chk("read_data", {8'h0, pingpong_data_out}, {8'h0, exp_q.pop_front()});
    end else if (pingpong_data_valid_out === 1'b0) begin
      chk("data_zero_when_idle", {8'h0, pingpong_data_out}, 32'h0);
    end
  end

  typedef struct {
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          rd;
    logic          flush;
    logic          e_wr_ready;
    logic          e_pp_ready;
    logic          e_valid;
    logic          e_underrun;
    logic [1:0]    e_full;
  } vec_t;

  vec_t vecs[8];

  task automatic idle_inputs();
    wr_valid_in = 1'b0; wr_data_in = '0; wr_last_in = 1'b0;
    read_pingpong_in = 1'b0; flush_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input logic last);
    wr_valid_in = 1'b1; wr_data_in = d; wr_last_in = last;
    exp_q.push_back(d);
    tick();
    wr_valid_in = 1'b0; wr_last_in = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_ready"}, {31'h0, wr_ready_out}, 32'd1);
    chk({tag, "_pp_ready"}, {31'h0, pingpong_ready_out}, 32'd0);
    chk({tag, "_valid"}, {31'h0, pingpong_data_valid_out}, 32'd0);
    chk({tag, "_data"}, {8'h0, pingpong_data_out}, 32'd0);
    chk({tag, "_underrun"}, {31'h0, underrun_out}, 32'd0);
    chk({tag, "_bank_full"}, {30'h0, bank_full_out}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset_values("reset");

    // Underrun on empty read, 3-word partial bank via wr_last, then flush.
    vecs[0] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[1] = '{1'b1, 24'hA0000A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[2] = '{1'b1, 24'hB0000B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[3] = '{1'b1, 24'hC0000C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[4] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    vecs[5] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    vecs[6] = '{1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    vecs[7] = '{1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};

    for (int i = 0; i < 8; i++) begin
      wr_valid_in = vecs[i].wr_valid; wr_data_in = vecs[i].wr_data;
      wr_last_in = vecs[i].wr_last; read_pingpong_in = vecs[i].rd;
      flush_in = vecs[i].flush;
      if (vecs[i].wr_valid) exp_q.push_back(vecs[i].wr_data);
      tick();
      if (vecs[i].flush) exp_q.delete();
      chk($sformatf("vec%0d_wr_ready", i), {31'h0, wr_ready_out}, {31'h0, vecs[i].e_wr_ready});
      chk($sformatf("vec%0d_pp_ready", i), {31'h0, pingpong_ready_out}, {31'h0, vecs[i].e_pp_ready});
      chk($sformatf("vec%0d_valid", i), {31'h0, pingpong_data_valid_out}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d_underrun", i), {31'h0, underrun_out}, {31'h0, vecs[i].e_underrun});
      chk($sformatf("vec%0d_bank_full", i), {30'h0, bank_full_out}, {30'h0, vecs[i].e_full});
    end
    idle_inputs();
    tick();

    // Fill one bank with 0..7; ready only after the 8th write.
    for (int i = 0; i < 8; i++) begin
      write_word(DW'(i), 1'b0);
      if (i == 6) chk("fill_pp_ready_before_last", {31'h0, pingpong_ready_out}, 32'd0);
    end
    chk("fill_pp_ready", {31'h0, pingpong_ready_out}, 32'd1);
    chk("fill_bank_full", {30'h0, bank_full_out}, 32'd1);
    read_pingpong_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain_valid%0d", i), {31'h0, pingpong_data_valid_out}, 32'd1);
    end
    read_pingpong_in = 1'b0;
    chk("drain_pp_ready_after", {31'h0, pingpong_ready_out}, 32'd0);
    tick();
    chk("drain_valid_drops", {31'h0, pingpong_data_valid_out}, 32'd0);

    // 16 continuous writes fill both banks and stall the writer.
    wr_valid_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data_in = DW'(16 + i);
      exp_q.push_back(wr_data_in);
      tick();
      if (i == 7) chk("both_fill_half_wr_ready", {31'h0, wr_ready_out}, 32'd1);
    end
    wr_valid_in = 1'b0;
    chk("both_full_flags", {30'h0, bank_full_out}, 32'd3);
    chk("both_full_wr_ready", {31'h0, wr_ready_out}, 32'd0);

    // 16 reads back to back across the bank boundary; valid must never drop.
    read_pingpong_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("cross_valid%0d", i), {31'h0, pingpong_data_valid_out}, 32'd1);
      if (i < 7) chk($sformatf("cross_wr_ready%0d", i), {31'h0, wr_ready_out}, 32'd0);
      if (i == 7) chk("cross_wr_ready_release", {31'h0, wr_ready_out}, 32'd1);
    end
    read_pingpong_in = 1'b0;
    tick();
    chk("cross_end_valid", {31'h0, pingpong_data_valid_out}, 32'd0);
    chk("cross_end_full", {30'h0, bank_full_out}, 32'd0);

    // Reset in the middle of draining a full bank, then refill and read back.
    for (int i = 0; i < 8; i++) write_word(DW'(32'h200 + i), 1'b0);
    read_pingpong_in = 1'b1;
    repeat (3) tick();
    read_pingpong_in = 1'b0;
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    check_reset_values("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) write_word(DW'(32'h300 + i), 1'b0);
    chk("refill_bank_full", {30'h0, bank_full_out}, 32'd1);
    read_pingpong_in = 1'b1;
    repeat (8) tick();
    read_pingpong_in = 1'b0;
    repeat (2) tick();
    chk("refill_pp_ready_after", {31'h0, pingpong_ready_out}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
